// File: rtl/mips_alu_unit.sv
// rtl/mips_alu_unit.sv - execute-stage ALU, ALU control decode, zero flag and PC adders
//
// Purpose:
//   Execute-stage arithmetic for the single-cycle MIPS-lite datapath. Decodes
//   aluop/funct into a 3-bit ALU function, computes the 32-bit ALU result,
//   produces PC+4 and the branch target, and keeps a registered status Z flag.
//   The Z flag is read by the branch-and-link-register-if-zero (balrz) path.
//
// Configuration:
//   BALRZ_EN  defined   : balrz decode and zero-flag register are built.
//             undefined : balrz = 0, zero = 0, funct 0110 decodes as "other".
//
// Ports:
//   clk            in   1   clock; zero flag updates on the rising edge
//   rst_n          in   1   asynchronous active-low reset (clears zero only)
//   aluop          in   2   ALU operation class from main control
//   funct          in   4   instruction bits [3:0]
//   a              in  32   ALU operand A
//   b              in  32   ALU operand B
//   pc             in  32   current program counter
//   offset_sl2     in  32   sign-extended immediate shifted left by 2
//   gout           out  3   decoded ALU function
//   balrz          out  1   R-type instruction decodes as balrz
//   sum            out 32   ALU result
//   zout           out  1   combinational zero of sum
//   zero           out  1   registered status Z flag
//   pc_plus4       out 32   pc + 4
//   branch_target  out 32   pc_plus4 + offset_sl2

module mips_alu_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  aluop,
  input  logic [3:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] pc,
  input  logic [31:0] offset_sl2,
  output logic [2:0]  gout,
  output logic        balrz,
  output logic [31:0] sum,
  output logic        zout,
  output logic        zero,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target
);

  localparam logic [2:0] G_AND = 3'b000;
  localparam logic [2:0] G_OR  = 3'b001;
  localparam logic [2:0] G_ADD = 3'b010;
  localparam logic [2:0] G_SUB = 3'b110;
  localparam logic [2:0] G_SLT = 3'b111;

  logic [2:0]  gout_dec;
  logic        balrz_dec;
  logic [31:0] alu_res;
  logic        is_rtype;

  assign is_rtype = (aluop == 2'b10);

  // ALU control decode; unlisted funct codes fall back to add.
  always_comb begin
    gout_dec  = G_ADD;
    balrz_dec = 1'b0;
    case (aluop)
      2'b00: gout_dec = G_ADD;
      2'b01: gout_dec = G_SUB;
      2'b11: gout_dec = G_OR;
      default: begin
        case (funct)
          4'b0000: gout_dec = G_ADD;
          4'b0010: gout_dec = G_SUB;
          4'b0100: gout_dec = G_AND;
          4'b0101: gout_dec = G_OR;
          4'b1010: gout_dec = G_SLT;
`ifdef BALRZ_EN
          4'b0110: begin
            gout_dec  = G_ADD;
            balrz_dec = 1'b1;
          end
`endif
          default: gout_dec = G_ADD;
        endcase
      end
    endcase
  end

  // slt uses a true signed compare so that overflow in a - b cannot flip it.
  always_comb begin
    alu_res = 32'h0;
    case (gout_dec)
      G_AND: alu_res = a & b;
      G_OR:  alu_res = a | b;
      G_ADD: alu_res = a + b;
      G_SUB: alu_res = a - b;
      G_SLT: alu_res = {31'h0, ($signed(a) < $signed(b))};
      default: alu_res = 32'h0;
    endcase
  end

  assign gout          = gout_dec;
  assign balrz         = balrz_dec;
  assign sum           = alu_res;
  assign zout          = (alu_res == 32'h0);
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + offset_sl2;

`ifdef BALRZ_EN
  logic zero_q;
  logic zero_d;

  // Only ordinary R-type results commit the flag; balrz and I-type ops hold it.
  always_comb begin
    zero_d = zero_q;
    if (is_rtype && !balrz_dec) begin
      zero_d = zout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;
`else
  // No flag register in this build; clock, reset and the R-type qualifier are idle.
  logic unused_flag_inputs;
  assign unused_flag_inputs = clk ^ rst_n ^ is_rtype;
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_mips_alu_unit.sv
// tb/tb_mips_alu_unit.sv - self-checking bench for mips_alu_unit

module tb_mips_alu_unit;

`ifdef BALRZ_EN
  localparam bit BALRZ_ON = 1'b1;
`else
  localparam bit BALRZ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  aluop = 2'b00;
  logic [3:0]  funct = 4'h0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic [31:0] pc = 32'h0;
  logic [31:0] offset_sl2 = 32'h0;
  logic [2:0]  gout;
  logic        balrz;
  logic [31:0] sum;
  logic        zout;
  logic        zero;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;

  int checks = 0;
  int errors = 0;
  bit model_zero = 1'b0;

  mips_alu_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .aluop         (aluop),
    .funct         (funct),
    .a             (a),
    .b             (b),
    .pc            (pc),
    .offset_sl2    (offset_sl2),
    .gout          (gout),
    .balrz         (balrz),
    .sum           (sum),
    .zout          (zout),
    .zero          (zero),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  aluop;
    logic [3:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] off;
    logic [2:0]  e_gout;
    logic        e_balrz;
    logic [31:0] e_sum;
    logic        e_zout;
    logic [31:0] e_pc4;
    logic [31:0] e_bt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: instruction class -> operation name -> plain arithmetic.
  function automatic string ref_op(input logic [1:0] op, input logic [3:0] fn);
    if (op == 2'b00) return "add";
    if (op == 2'b01) return "sub";
    if (op == 2'b11) return "or";
    if (fn == 4'b0000) return "add";
    if (fn == 4'b0010) return "sub";
    if (fn == 4'b0100) return "and";
    if (fn == 4'b0101) return "or";
    if (fn == 4'b1010) return "slt";
    if (fn == 4'b0110 && BALRZ_ON) return "balrz";
    return "add";
  endfunction

  function automatic logic [2:0] ref_gout(input string o);
    if (o == "and") return 3'b000;
    if (o == "or")  return 3'b001;
    if (o == "sub") return 3'b110;
    if (o == "slt") return 3'b111;
    return 3'b010;
  endfunction

  function automatic logic [31:0] ref_sum(input string o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == "and") return x & y;
    if (o == "or")  return x | y;
    if (o == "sub") return 32'((64'(x) + 64'h1_0000_0000 - 64'(y)) % 64'h1_0000_0000);
    if (o == "slt") return (sx < sy) ? 32'd1 : 32'd0;
    return 32'((64'(x) + 64'(y)) % 64'h1_0000_0000);
  endfunction

  // Apply one instruction at posedge+1, check combinational outputs, then the flag after the edge.
  task automatic step(input logic [1:0] op, input logic [3:0] fn, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] p, input logic [31:0] off,
                      input string tag);
    string o;
    logic [31:0] s;
    o = ref_op(op, fn);
    s = ref_sum(o, x, y);
    aluop = op; funct = fn; a = x; b = y; pc = p; offset_sl2 = off;
    #2;
    check({tag, ".gout"}, 32'(gout), 32'(ref_gout(o)));
    check({tag, ".balrz"}, 32'(balrz), 32'(o == "balrz"));
    check({tag, ".sum"}, sum, s);
    check({tag, ".zout"}, 32'(zout), 32'(s == 32'h0));
    check({tag, ".pc4"}, pc_plus4, 32'((64'(p) + 64'd4) % 64'h1_0000_0000));
    check({tag, ".bt"}, branch_target, 32'((64'(p) + 64'd4 + 64'(off)) % 64'h1_0000_0000));
    check({tag, ".zero_pre"}, 32'(zero), 32'(model_zero));
    if (BALRZ_ON && op == 2'b10 && o != "balrz") model_zero = (s == 32'h0);
    @(posedge clk);
    #1;
    check({tag, ".zero_post"}, 32'(zero), 32'(model_zero));
  endtask

  initial begin
    vec_t v;
    logic [3:0] fsel[8];
    fsel = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b1010, 4'b0110, 4'b1111, 4'b0011};

    vecs.push_back('{2'b00, 4'h0, 32'h1, 32'h2, 32'h10, 32'hFFFF_FFF8, 3'b010, 1'b0, 32'h3, 1'b0, 32'h14, 32'hC});
    vecs.push_back('{2'b01, 4'h0, 32'h5, 32'h3, 32'hFFFF_FFFC, 32'h0, 3'b110, 1'b0, 32'h2, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{2'b11, 4'h0, 32'hF0, 32'hF, 32'h100, 32'h20, 3'b001, 1'b0, 32'hFF, 1'b0, 32'h104, 32'h124});
    vecs.push_back('{2'b10, 4'b0000, 32'hF0, 32'hF, 32'h100, 32'h20, 3'b010, 1'b0, 32'hFF, 1'b0, 32'h104, 32'h124});
    vecs.push_back('{2'b10, 4'b0010, 32'hF0, 32'hF, 32'h100, 32'h20, 3'b110, 1'b0, 32'hE1, 1'b0, 32'h104, 32'h124});
    vecs.push_back('{2'b10, 4'b0100, 32'hF0, 32'hF, 32'h100, 32'h20, 3'b000, 1'b0, 32'h0, 1'b1, 32'h104, 32'h124});
    vecs.push_back('{2'b10, 4'b0101, 32'hF0, 32'hF, 32'h100, 32'h20, 3'b001, 1'b0, 32'hFF, 1'b0, 32'h104, 32'h124});
    vecs.push_back('{2'b10, 4'b1010, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 3'b111, 1'b0, 32'h1, 1'b0, 32'h104, 32'h124});
    vecs.push_back('{2'b10, 4'b1010, 32'h7FFF_FFFF, 32'h8000_0000, 32'h100, 32'h20, 3'b111, 1'b0, 32'h0, 1'b1, 32'h104, 32'h124});
    vecs.push_back('{2'b10, 4'b0110, 32'h1, 32'h1, 32'h100, 32'h20, 3'b010, BALRZ_ON, 32'h2, 1'b0, 32'h104, 32'h124});
    vecs.push_back('{2'b10, 4'b1111, 32'h3, 32'h4, 32'h100, 32'h20, 3'b010, 1'b0, 32'h7, 1'b0, 32'h104, 32'h124});
    vecs.push_back('{2'b01, 4'b0110, 32'h1, 32'h1, 32'h100, 32'h20, 3'b110, 1'b0, 32'h0, 1'b1, 32'h104, 32'h124});

    // Table vectors run under reset: combinational paths ignore it and zero must stay 0.
    #1;
    check("reset.zero", 32'(zero), 32'h0);
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      aluop = v.aluop; funct = v.funct; a = v.a; b = v.b; pc = v.pc; offset_sl2 = v.off;
      #3;
      check($sformatf("vec%0d.gout", i), 32'(gout), 32'(v.e_gout));
      check($sformatf("vec%0d.balrz", i), 32'(balrz), 32'(v.e_balrz));
      check($sformatf("vec%0d.sum", i), sum, v.e_sum);
      check($sformatf("vec%0d.zout", i), 32'(zout), 32'(v.e_zout));
      check($sformatf("vec%0d.pc4", i), pc_plus4, v.e_pc4);
      check($sformatf("vec%0d.bt", i), branch_target, v.e_bt);
      check($sformatf("vec%0d.zero", i), 32'(zero), 32'h0);
    end

    // Flag sequencing after reset release.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_zero = 1'b0;
    step(2'b10, 4'b0010, 32'd5, 32'd5, 32'h0, 32'h0, "seq_sub");
    check("seq_sub.zero_is_1", 32'(zero), 32'(BALRZ_ON));
    step(2'b00, 4'b0000, 32'd3, 32'd4, 32'h0, 32'h0, "seq_lw");
    check("seq_lw.zero_holds", 32'(zero), 32'(BALRZ_ON));
    step(2'b10, 4'b0110, 32'd1, 32'd1, 32'h0, 32'h0, "seq_balrz");
    check("seq_balrz.zero_holds", 32'(zero), 32'(BALRZ_ON));
    step(2'b10, 4'b0000, 32'd1, 32'd1, 32'h0, 32'h0, "seq_add");
    check("seq_add.zero_is_0", 32'(zero), 32'h0);

    // Async reset between edges, then the first edge after release updates normally.
    step(2'b10, 4'b0010, 32'd9, 32'd9, 32'h0, 32'h0, "ar_set");
    check("ar_set.zero_is_1", 32'(zero), 32'(BALRZ_ON));
    #2;
    rst_n = 1'b0;
    #1;
    check("ar.zero_cleared", 32'(zero), 32'h0);
    model_zero = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    if (BALRZ_ON) model_zero = 1'b1;
    check("ar.first_edge", 32'(zero), 32'(model_zero));

    // Randomized instructions against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic [1:0] op;
      logic [3:0] fn;
      logic [31:0] x, y;
      op = 2'($urandom_range(0, 3));
      fn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : fsel[$urandom_range(0, 7)];
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? x : $urandom;
      if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
      step(op, fn, x, y, $urandom, $urandom, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
